// File: rtl/sep32_frame_pkg.sv
// Shared constants and state encodings for the sep32 frame collector.
package sep32_frame_pkg;

    localparam int DW_DEF = 10;                   // default sample width
    localparam int SLOTS  = 32;                   // slots per frame
    localparam int SLOT_W = $clog2(SLOTS);        // slot index width

    localparam logic [SLOT_W-1:0] SLOT_FIRST = '0;
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SLOTS - 1);

    // Capture side: hunting for the frame marker, or filling a bank.
    typedef enum logic {
        HUNT = 1'b0,
        FILL = 1'b1
    } cap_state_e;

    // Read side: nothing to send, or streaming a completed bank.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } rd_state_e;

endpackage

// File: rtl/sep32_cnt.sv
// Slot counter: tracks the slot index of the most recent cen sample.
// The zero marker forces slot 0; otherwise the index wraps modulo 32.
module sep32_cnt
    import sep32_frame_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cen,
    input  logic              i_zero,
    output logic [SLOT_W-1:0] o_wslot
);

    logic [SLOT_W-1:0] r_wslot;

    // Advance once per cen cycle; the marker resynchronises to slot 0.
    always_ff @(posedge clk) begin
        if (rst)
            r_wslot <= '0;
        else if (i_cen)
            r_wslot <= i_zero ? '0 : r_wslot + 1'b1;
    end

    assign o_wslot = r_wslot;

endmodule

// File: rtl/sep32_frame.sv
// sep32_frame: collects 32-slot frames from a cen-qualified serial stream
// into a double-buffered bank and streams completed frames as 32 beats.
module sep32_frame
    import sep32_frame_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic              zero,
    input  logic [DW-1:0]     din,
    output logic              locked,
    output logic              sync_err,
    output logic              ovf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SLOT_W-1:0] out_slot,
    output logic [DW-1:0]     out_data,
    output logic              out_last
);

    // Two banks of 32 samples; contents are deliberately not reset.
    logic [1:0][SLOTS-1:0][DW-1:0] r_bank;

    cap_state_e        r_cap, w_cap_nxt;
    rd_state_e         r_rd,  w_rd_nxt;
    logic              r_locked, w_locked_nxt;
    logic              r_sync_err, r_ovf;
    logic              r_wbank, r_rbank;
    logic [SLOT_W-1:0] r_slot, w_slot_nxt;

    logic [SLOT_W-1:0] w_wslot;   // slot of the last accepted sample
    logic [SLOT_W-1:0] w_exp;     // slot expected on this cen cycle
    logic              w_we;
    logic [SLOT_W-1:0] w_waddr;
    logic              w_serr;
    logic              w_done;    // slot 31 written this cycle
    logic              w_rd_free; // reader can take a new bank now
    logic              w_load;
    logic              w_drop;

    sep32_cnt u_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_cen   (cen),
        .i_zero  (zero),
        .o_wslot (w_wslot)
    );

    assign w_exp = w_wslot + 1'b1;

    // Capture FSM next-state: marker checks, bank write strobe, completion.
    always_comb begin
        w_cap_nxt    = r_cap;
        w_locked_nxt = r_locked;
        w_we         = 1'b0;
        w_waddr      = w_exp;
        w_serr       = 1'b0;
        w_done       = 1'b0;
        if (cen) begin
            case (r_cap)
                HUNT: begin
                    if (zero) begin
                        w_we         = 1'b1;
                        w_waddr      = SLOT_FIRST;
                        w_cap_nxt    = FILL;
                        w_locked_nxt = 1'b1;
                    end
                end
                FILL: begin
                    if (zero && (w_exp != SLOT_FIRST)) begin
                        // Early marker: restart the frame in the same bank.
                        w_serr  = 1'b1;
                        w_we    = 1'b1;
                        w_waddr = SLOT_FIRST;
                    end else if (!zero && (w_exp == SLOT_FIRST)) begin
                        // Marker missing where it must be: lose lock.
                        w_serr       = 1'b1;
                        w_locked_nxt = 1'b0;
                        w_cap_nxt    = HUNT;
                    end else begin
                        w_we    = 1'b1;
                        w_waddr = w_exp;
                        w_done  = (w_exp == SLOT_LAST);
                    end
                end
                default: w_cap_nxt = HUNT;
            endcase
        end
    end

    // A completed frame is handed over only if the reader is free now.
    assign w_rd_free = (r_rd == IDLE) ||
                       ((r_slot == SLOT_LAST) && out_ready);
    assign w_load    = w_done &&  w_rd_free;
    assign w_drop    = w_done && !w_rd_free;

    // Reader FSM next-state: a fresh bank load wins over beat advance.
    always_comb begin
        w_rd_nxt   = r_rd;
        w_slot_nxt = r_slot;
        if (w_load) begin
            w_rd_nxt   = SEND;
            w_slot_nxt = SLOT_FIRST;
        end else if ((r_rd == SEND) && out_ready) begin
            if (r_slot == SLOT_LAST) begin
                w_rd_nxt   = IDLE;
                w_slot_nxt = SLOT_FIRST;
            end else begin
                w_slot_nxt = r_slot + 1'b1;
            end
        end
    end

    // State, bank pointers and registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap      <= HUNT;
            r_rd       <= IDLE;
            r_locked   <= 1'b0;
            r_sync_err <= 1'b0;
            r_ovf      <= 1'b0;
            r_slot     <= '0;
            r_wbank    <= 1'b0;
            r_rbank    <= 1'b1;
        end else begin
            r_cap      <= w_cap_nxt;
            r_rd       <= w_rd_nxt;
            r_locked   <= w_locked_nxt;
            r_sync_err <= w_serr;
            r_ovf      <= w_drop;
            r_slot     <= w_slot_nxt;
            if (w_load) begin
                r_rbank <= r_wbank;
                r_wbank <= ~r_wbank;
            end
        end
    end

    // Sample write into the capture bank; suppressed while in reset.
    always_ff @(posedge clk) begin
        if (!rst && w_we)
            r_bank[r_wbank][w_waddr] <= din;
    end

    assign locked    = r_locked;
    assign sync_err  = r_sync_err;
    assign ovf       = r_ovf;
    assign out_valid = (r_rd == SEND);
    assign out_slot  = r_slot;
    assign out_data  = r_bank[r_rbank][r_slot];
    assign out_last  = (r_rd == SEND) && (r_slot == SLOT_LAST);

endmodule

// File: tb/tb_sep32_frame.sv
// Directed bench for sep32_frame. Sample values encode {frame id, slot}
// so every beat identifies which frame and slot it must come from.
module tb_sep32_frame;

    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst, cen, zero, out_ready;
    logic [DW-1:0] din;
    logic          locked, sync_err, ovf, out_valid, out_last;
    logic [4:0]    out_slot;
    logic [DW-1:0] out_data;

    int n_vec = 0;
    int n_err = 0;
    int serr_cnt = 0;
    int ovf_cnt = 0;
    int frames = 0;
    int exp_q[$];
    bit rnd_rdy = 1'b0;

    sep32_frame #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .zero      (zero),
        .din       (din),
        .locked    (locked),
        .sync_err  (sync_err),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_slot  (out_slot),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, settle 1 time unit.
    task automatic cyc(input logic c, input logic z, input logic [DW-1:0] d);
        cen  = c;
        zero = z;
        din  = d;
        if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
    endtask

    // Slots from..to of frame fid, with gap idle cycles after each.
    task automatic slots(input int fid, input int from, input int to, input int gap);
        for (int s = from; s <= to; s++) begin
            cyc(1'b1, s == 0, {5'(fid), 5'(s)});
            repeat (gap) cyc(1'b0, 1'b0, '1);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && (exp_q.size() != 0 || out_valid); i++)
            cyc(1'b0, 1'b0, '0);
        chk("drain_done", {exp_q.size() == 0, out_valid}, 32'b10);
    endtask

    // Beat monitor: checks order, content, last flag and hold stability.
    initial begin
        int         mon_slot;
        bit         prev_hold;
        logic [15:0] prev_vec;
        logic [DW-1:0] e;
        mon_slot  = 0;
        prev_hold = 1'b0;
        prev_vec  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                mon_slot  = 0;
                prev_hold = 1'b0;
            end else begin
                if (sync_err) serr_cnt++;
                if (ovf)      ovf_cnt++;
                if (prev_hold) chk("hold", {out_slot, out_data, out_last}, prev_vec);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexp_beat", exp_q.size(), 1);
                    end else begin
                        e = {5'(exp_q[0]), 5'(mon_slot)};
                        chk("beat_slot", out_slot, mon_slot);
                        chk("beat_data", out_data, e);
                        chk("beat_last", out_last, mon_slot == 31);
                        if (mon_slot == 31) begin
                            void'(exp_q.pop_front());
                            frames++;
                            mon_slot = 0;
                        end else begin
                            mon_slot++;
                        end
                    end
                end
                prev_hold = out_valid && !out_ready;
                prev_vec  = {out_slot, out_data, out_last};
            end
        end
    end

    initial begin
        rst = 1'b1; cen = 1'b0; zero = 1'b0; din = '0; out_ready = 1'b1;
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        chk("rst_locked", locked, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_slot", out_slot, 0);
        chk("rst_last", out_last, 0);
        chk("rst_serr", sync_err, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;

        // Clean back-to-back frames, cen every clock.
        exp_q.push_back(8);
        exp_q.push_back(9);
        chk("pre_lock", locked, 0);
        cyc(1'b1, 1'b1, 10'h100);
        chk("lock_rise", locked, 1);
        slots(8, 1, 30, 0);
        chk("no_valid_early", out_valid, 0);
        slots(8, 31, 31, 0);
        chk("lat_valid", out_valid, 1);
        chk("lat_slot", out_slot, 0);
        chk("lat_data", out_data, 10'h100);
        slots(9, 0, 31, 0);
        wait_drain();
        chk("basic_serr", serr_cnt, 0);
        chk("basic_ovf", ovf_cnt, 0);
        chk("basic_frames", frames, 2);

        // Early marker at slot 17: partial frame 10 discarded.
        exp_q.push_back(11);
        slots(10, 0, 16, 0);
        cyc(1'b1, 1'b1, {5'd11, 5'd0});
        chk("early_serr", sync_err, 1);
        cyc(1'b1, 1'b0, {5'd11, 5'd1});
        chk("early_serr_clr", sync_err, 0);
        chk("early_locked", locked, 1);
        slots(11, 2, 31, 0);
        wait_drain();
        chk("early_serr_cnt", serr_cnt, 1);
        chk("early_frames", frames, 3);

        // Missing marker at slot 0: unlock, ignore data until next marker.
        cyc(1'b1, 1'b0, 10'h3AA);
        chk("miss_serr", sync_err, 1);
        chk("miss_unlock", locked, 0);
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, {5'd12, 5'(i)});
        chk("hunt_locked", locked, 0);
        chk("miss_serr_cnt", serr_cnt, 2);
        exp_q.push_back(13);
        slots(13, 0, 31, 0);
        wait_drain();
        chk("miss_frames", frames, 4);

        // Stalled consumer across the next completion: frame 15 dropped.
        exp_q.push_back(14);
        slots(14, 0, 31, 0);
        out_ready = 1'b0;
        slots(15, 0, 30, 0);
        chk("ovf_pre", ovf, 0);
        slots(15, 31, 31, 0);
        chk("ovf_pulse", ovf, 1);
        cyc(1'b0, 1'b0, '0);
        chk("ovf_clr", ovf, 0);
        chk("ovf_hold_slot", out_slot, 0);
        chk("ovf_hold_data", out_data, {5'd14, 5'd0});
        repeat (7) cyc(1'b0, 1'b0, '0);
        out_ready = 1'b1;
        wait_drain();
        chk("ovf_cnt", ovf_cnt, 1);
        chk("ovf_frames", frames, 5);
        exp_q.push_back(16);
        slots(16, 0, 31, 0);
        wait_drain();
        chk("post_ovf_frames", frames, 6);

        // Sparse cen with a randomly stalling consumer.
        rnd_rdy = 1'b1;
        exp_q.push_back(17);
        exp_q.push_back(18);
        exp_q.push_back(19);
        slots(17, 0, 31, 2);
        slots(18, 0, 31, 2);
        slots(19, 0, 31, 2);
        wait_drain();
        rnd_rdy = 1'b0;
        out_ready = 1'b1;
        chk("rnd_ovf", ovf_cnt, 1);
        chk("rnd_frames", frames, 9);

        // Reset during readout at beat 10.
        exp_q.push_back(20);
        slots(20, 0, 31, 0);
        for (int i = 0; i < 60 && !(out_valid && out_slot == 5'd10); i++)
            cyc(1'b0, 1'b0, '0);
        chk("reach_beat10", {out_valid, out_slot}, {1'b1, 5'd10});
        rst = 1'b1;
        cyc(1'b0, 1'b0, '0);
        chk("rrst_valid", out_valid, 0);
        chk("rrst_locked", locked, 0);
        chk("rrst_slot", out_slot, 0);
        rst = 1'b0;
        exp_q.push_back(21);
        slots(21, 0, 31, 0);
        wait_drain();
        chk("final_frames", frames, 10);
        chk("final_serr", serr_cnt, 2);
        chk("final_ovf", ovf_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
